uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- UART 8N1 receiver with an on-chip receive FIFO. It is the receiving end of the CPU's uart_tx_o serial stream.
- Used as the host/peer-side endpoint in FPGA test systems and as a loopback checker for the rv32 subsystem.
- Deserialises bytes from uart_rx_i and buffers them in a first-word-fall-through FIFO.
- Exposes sticky framing-error and overflow flags to a simple pop interface.

Parameters:
- CLK_FREQ, 50000000: clock frequency in Hz.
- BAUD_RATE, 115200: serial bit rate.
- FIFO_DEPTH, 16: receive FIFO entries; power of 2, minimum 2.
- Derived CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division); must be at least 4.
- Derived HALF_BIT = CLKS_PER_BIT/2.

Ports:
- clk_i  input  1  system clock
- reset_i  input  1  reset; asynchronous, active-high
- uart_rx_i  input  1  serial input; idle high; asynchronous to clk_i
- rd_en_i  input  1  pop head of FIFO
- clear_err_i  input  1  clears frame_err_o and overflow_o
- data_o  output  8  FIFO head byte; valid only when valid_o=1
- valid_o  output  1  FIFO non-empty
- count_o  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy
- frame_err_o  output  1  sticky: a stop bit was sampled low
- overflow_o  output  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset:
  - Async assert clears all state: FSM to IDLE, counters, FIFO pointers, data_o=0, valid_o=0, count_o=0, frame_err_o=0, overflow_o=0.
  - The 2-FF synchroniser resets to 1 (line idle).
- Input path: uart_rx_i passes through a 2-FF synchroniser (rx_s). All sampling uses rx_s.
- Bit counter: one clk-cycle counter, cleared on every state transition.
- FSM transitions:
  - IDLE: rx_s==0 -> START.
  - START: at counter==HALF_BIT-1, sample rx_s. If 0 -> DATA, bit_idx=0. If 1 -> IDLE (glitch rejected, nothing recorded).
  - DATA: at counter==CLKS_PER_BIT-1, shift rx_s into bit bit_idx (LSB first) and increment bit_idx. After bit 7 -> STOP.
  - STOP: at counter==CLKS_PER_BIT-1, sample rx_s.
    - If 1: push the byte and go to IDLE.
    - If 0: set frame_err_o, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then go to IDLE. A break condition (line held low) yields exactly one frame error.
- Back-to-back frames: the next start bit is detected in IDLE in the cycle after STOP; no idle gap is required.
- FIFO:
  - First-word fall-through: data_o = mem[rd_ptr] combinationally; valid_o = (count_o != 0).
  - Push latency: valid_o and count_o update on the clock edge after the stop-bit sample cycle.
  - Pop occurs when rd_en_i && valid_o. rd_en_i while empty is ignored; count stays 0 and no underflow flag exists.
  - Push while full with no pop: byte dropped, overflow_o set, FIFO contents unchanged.
  - Push and pop in the same cycle, FIFO full: both occur; no overflow; count unchanged.
  - Push and pop in the same cycle, FIFO empty: push only. The pop is ignored because valid_o was 0.
  - Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. count_o tracks occupancy separately and saturates nowhere; it is never greater than FIFO_DEPTH.
- Error flags:
  - clear_err_i clears both flags on the next edge.
  - If a set event and clear_err_i coincide in the same cycle, set wins.
- Reset mid-frame: the partial byte is lost. After reset is released, the receiver waits for rx_s==0 in IDLE.

Test Plan:
(bench params: CLK_FREQ=1000000, BAUD_RATE=100000, so CLKS_PER_BIT=10, HALF_BIT=5; FIFO_DEPTH=16)
1. Drive 0xA5 8N1 from idle -> one cycle after the stop sample: valid_o=1, data_o=0xA5, count_o=1. Pulse rd_en_i -> valid_o=0, count_o=0, no error flags.
2. Pull the line low for 3 cycles, then high -> no push, flags 0. A following 0x5A frame is received correctly.
3. Send 0x3C with stop bit low, hold the line low for 30 cycles, then high -> frame_err_o=1, count_o=0. Next frame 0x55 is received with data_o=0x55. clear_err_i -> frame_err_o=0.
4. Send 17 bytes 0x00..0x10 with no reads -> count_o=16, overflow_o=1. Popping yields 0x00..0x0F in order and 0x10 is absent. Then send one byte while full and pulse rd_en_i in its push cycle -> count_o stays 16, no new overflow.
5. Send 0x01, 0x80, 0xFF back-to-back with no idle bits -> all three are received in order, count_o=3.
6. Assert reset_i mid-DATA of 0x77 -> all outputs 0 immediately. Release reset, then send 0x99 -> data_o=0x99, count_o=1.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: pop-side bus of the UART receive FIFO (status flags, head byte, pop/clear strobes)
interface uart_rx_fifo_if #(parameter int FIFO_DEPTH = 16);
   logic                              rd_en_i;
   logic                              clear_err_i;
   logic [7:0]                        data_o;
   logic                              valid_o;
   logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o;
   logic                              frame_err_o;
   logic                              overflow_o;
   modport master (output rd_en_i, clear_err_i, input data_o, valid_o, count_o, frame_err_o, overflow_o);
   modport slave (input rd_en_i, clear_err_i, output data_o, valid_o, count_o, frame_err_o, overflow_o);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through FIFO with sticky error flags
module uart_rx_fifo #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic uart_rx_i,
   uart_rx_fifo_if.slave bus
);
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int NW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
   localparam logic [NW-1:0] FULL      = NW'(FIFO_DEPTH);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
   state_t          state, state_n;
   logic            rx_meta, rx_s;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [NW-1:0]   count;
   logic            frame_err, overflow;
   logic            bit_end, push, ferr_set, pop, wr, full;
   assign bit_end  = cnt == BIT_LAST;
   assign push     = state == STOP && bit_end && rx_s;
   assign ferr_set = state == STOP && bit_end && !rx_s;
   assign full     = count == FULL;
   assign pop      = bus.rd_en_i && count != '0;
   // a full FIFO still accepts a byte when the same edge frees a slot
   assign wr       = push && (!full || pop);
   always_comb begin
      state_n = state;
      case (state)
         IDLE:      state_n = rx_s ? IDLE : START;
         START:     if (cnt == HALF_LAST) state_n = rx_s ? IDLE : DATA;
         DATA:      if (bit_end && bit_idx == 3'd7) state_n = STOP;
         STOP:      if (bit_end) state_n = rx_s ? IDLE : WAIT_IDLE;
         WAIT_IDLE: state_n = rx_s ? IDLE : WAIT_IDLE;
         default:   state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rx_meta   <= 1'b1;
         rx_s      <= 1'b1;
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         rx_meta   <= uart_rx_i;
         rx_s      <= rx_meta;
         state     <= state_n;
         cnt       <= (state_n != state || bit_end) ? '0 : cnt + 1'b1;
         bit_idx   <= state == START ? 3'd0 : (state == DATA && bit_end) ? bit_idx + 3'd1 : bit_idx;
         shreg     <= (state == DATA && bit_end) ? {rx_s, shreg[7:1]} : shreg;
         wr_ptr    <= wr ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr    <= pop ? rd_ptr + 1'b1 : rd_ptr;
         count     <= (wr && !pop) ? count + 1'b1 : (!wr && pop) ? count - 1'b1 : count;
         frame_err <= ferr_set || (frame_err && !bus.clear_err_i);
         overflow  <= (push && full && !pop) || (overflow && !bus.clear_err_i);
      end
   end
   always_ff @(posedge clk_i) begin
      if (wr) mem[wr_ptr] <= shreg;
   end
   assign bus.data_o      = count != '0 ? mem[rd_ptr] : 8'h00;
   assign bus.valid_o     = count != '0;
   assign bus.count_o     = count;
   assign bus.frame_err_o = frame_err;
   assign bus.overflow_o  = overflow;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed serial frames; expected bytes are queued and checked by a pop monitor
module tb_uart_rx_fifo;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;
   int n_chk = 0, n_fail = 0, m_chk = 0, m_fail = 0;
   logic [7:0] exp_q [$];
   uart_rx_fifo_if #(.FIFO_DEPTH(16)) bus ();
   uart_rx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .FIFO_DEPTH(16)) dut (
      .clk_i(clk), .reset_i(rst), .uart_rx_i(rx), .bus(bus)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (!rst && bus.rd_en_i && bus.valid_o) begin
         m_chk++;
         if (exp_q.size() == 0) begin
            m_fail++;
            $display("FAIL pop_data: got %02h, no byte expected", bus.data_o);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (bus.data_o !== e) begin
               m_fail++;
               $display("FAIL pop_data: got %02h expected %02h", bus.data_o, e);
            end
         end
      end
   end
   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   // stop_ok=0 sends a low stop bit; pop_stop pulses rd_en_i so the pop lands on the push edge
   task automatic send(input logic [7:0] b, input bit stop_ok = 1, input bit pop_stop = 0, input bit lat = 0);
      rx = 1'b0;
      cyc(10);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         cyc(10);
      end
      rx = stop_ok;
      cyc(7);
      if (lat) chk("push_latency_before", bus.valid_o, 0);
      if (pop_stop) bus.rd_en_i = 1'b1;
      cyc(1);
      bus.rd_en_i = 1'b0;
      if (lat) chk("push_latency_after", bus.valid_o, 1);
      cyc(2);
      rx = 1'b1;
   endtask
   task automatic pop1();
      bus.rd_en_i = 1'b1;
      cyc(1);
      bus.rd_en_i = 1'b0;
   endtask
   task automatic pop_all();
      for (int i = 0; i < 40 && bus.valid_o; i++) pop1();
   endtask
   task automatic clear();
      bus.clear_err_i = 1'b1;
      cyc(1);
      bus.clear_err_i = 1'b0;
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      bus.rd_en_i = 1'b0;
      bus.clear_err_i = 1'b0;
      #2;
      chk("rst_valid", bus.valid_o, 0);
      chk("rst_count", bus.count_o, 0);
      chk("rst_data", bus.data_o, 0);
      chk("rst_flags", {bus.frame_err_o, bus.overflow_o}, 0);
      cyc(3);
      rst = 1'b0;
      cyc(5);
      // 1: single byte, then pop
      exp_q.push_back(8'hA5);
      send(8'hA5, 1, 0, 1);
      chk("t1_valid", bus.valid_o, 1);
      chk("t1_data", bus.data_o, 8'hA5);
      chk("t1_count", bus.count_o, 1);
      pop1();
      chk("t1_empty_count", bus.count_o, 0);
      chk("t1_empty_valid", bus.valid_o, 0);
      chk("t1_flags", {bus.frame_err_o, bus.overflow_o}, 0);
      pop1();
      chk("t1_underflow_count", bus.count_o, 0);
      // 2: short glitch rejected
      rx = 1'b0;
      cyc(3);
      rx = 1'b1;
      cyc(20);
      chk("t2_glitch_count", bus.count_o, 0);
      chk("t2_glitch_flags", {bus.frame_err_o, bus.overflow_o}, 0);
      exp_q.push_back(8'h5A);
      send(8'h5A);
      chk("t2_data", bus.data_o, 8'h5A);
      pop1();
      // 3: framing error with break, then recovery
      send(8'h3C, 0);
      rx = 1'b0;
      cyc(30);
      rx = 1'b1;
      cyc(5);
      chk("t3_frame_err", bus.frame_err_o, 1);
      chk("t3_count", bus.count_o, 0);
      exp_q.push_back(8'h55);
      send(8'h55);
      chk("t3_data", bus.data_o, 8'h55);
      chk("t3_sticky", bus.frame_err_o, 1);
      pop1();
      clear();
      chk("t3_cleared", bus.frame_err_o, 0);
      // 4: overflow, then push+pop while full
      for (int i = 0; i < 17; i++) begin
         if (i < 16) exp_q.push_back(8'(i));
         send(8'(i));
      end
      chk("t4_count_full", bus.count_o, 16);
      chk("t4_overflow", bus.overflow_o, 1);
      chk("t4_head", bus.data_o, 8'h00);
      clear();
      chk("t4_ovf_cleared", bus.overflow_o, 0);
      exp_q.push_back(8'h20);
      send(8'h20, 1, 1);
      chk("t4_count_pushpop", bus.count_o, 16);
      chk("t4_no_new_ovf", bus.overflow_o, 0);
      pop_all();
      chk("t4_drained", bus.valid_o, 0);
      // 5: back-to-back frames
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h80);
      exp_q.push_back(8'hFF);
      send(8'h01);
      send(8'h80);
      send(8'hFF);
      chk("t5_count", bus.count_o, 3);
      pop_all();
      chk("t5_drained", bus.count_o, 0);
      // 6: reset mid-frame
      exp_q.push_back(8'h99);
      send(8'h11);
      rx = 1'b0;
      cyc(10);
      for (int i = 0; i < 3; i++) begin
         rx = 1'(8'h77 >> i);
         cyc(10);
      end
      rst = 1'b1;
      #1;
      chk("t6_rst_count", bus.count_o, 0);
      chk("t6_rst_valid", bus.valid_o, 0);
      chk("t6_rst_data", bus.data_o, 0);
      rx = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(5);
      chk("t6_idle_count", bus.count_o, 0);
      send(8'h99);
      chk("t6_data", bus.data_o, 8'h99);
      chk("t6_count", bus.count_o, 1);
      pop1();
      cyc(2);
      chk("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", (n_chk - n_fail) + (m_chk - m_fail), n_chk + m_chk);
      $finish;
   end
endmodule
